// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data-memory channel between LSUs
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready,
    output logic                               busy
);
    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_t;

    state_t state, state_next;

    logic [IDX_BITS-1:0] rr_ptr, rr_ptr_next;
    logic [IDX_BITS-1:0] grant, grant_next;
    logic [IDX_BITS-1:0] cand;
    logic [IDX_BITS-1:0] sel_idx;
    logic                found;
    logic                sel_read;
    logic [ADDR_BITS-1:0] sel_read_addr, sel_write_addr;
    logic [DATA_BITS-1:0] sel_write_data;

    logic                               mem_read_valid_next, mem_write_valid_next;
    logic [ADDR_BITS-1:0]               mem_read_address_next, mem_write_address_next;
    logic [DATA_BITS-1:0]               mem_write_data_next;
    logic [NUM_CONSUMERS-1:0]           read_ready_next, write_ready_next;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_next;
    logic                               busy_next;

    function automatic logic [IDX_BITS-1:0] wrap_idx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= NUM_CONSUMERS) sum = sum - NUM_CONSUMERS;
        return IDX_BITS'(sum);
    endfunction

    // First requester at or after rr_ptr; a read wins over a write from the same consumer.
    always_comb begin
        found          = 1'b0;
        sel_idx        = '0;
        cand           = '0;
        sel_read_addr  = '0;
        sel_write_addr = '0;
        sel_write_data = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = wrap_idx(int'(rr_ptr), k);
            if (!found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        sel_read = consumer_read_valid[sel_idx];
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (int'(sel_idx) == i) begin
                sel_read_addr  = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
                sel_write_addr = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                sel_write_data = consumer_write_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            grant                <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
            busy                 <= 1'b0;
        end else begin
            state                <= state_next;
            rr_ptr               <= rr_ptr_next;
            grant                <= grant_next;
            mem_read_valid       <= mem_read_valid_next;
            mem_read_address     <= mem_read_address_next;
            mem_write_valid      <= mem_write_valid_next;
            mem_write_address    <= mem_write_address_next;
            mem_write_data       <= mem_write_data_next;
            consumer_read_ready  <= read_ready_next;
            consumer_write_ready <= write_ready_next;
            consumer_read_data   <= read_data_next;
            busy                 <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (found) state_next = sel_read ? READ_WAIT : WRITE_WAIT;
            READ_WAIT:  if (mem_read_ready) state_next = RELEASE;
            WRITE_WAIT: if (mem_write_ready) state_next = RELEASE;
            RELEASE:    state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Ready bits default low so every pulse lasts exactly one cycle.
    always_comb begin
        rr_ptr_next            = rr_ptr;
        grant_next             = grant;
        mem_read_valid_next    = mem_read_valid;
        mem_read_address_next  = mem_read_address;
        mem_write_valid_next   = mem_write_valid;
        mem_write_address_next = mem_write_address;
        mem_write_data_next    = mem_write_data;
        read_ready_next        = '0;
        write_ready_next       = '0;
        read_data_next         = consumer_read_data;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next  = sel_idx;
                    rr_ptr_next = wrap_idx(int'(sel_idx), 1);
                    if (sel_read) begin
                        mem_read_valid_next   = 1'b1;
                        mem_read_address_next = sel_read_addr;
                    end else begin
                        mem_write_valid_next   = 1'b1;
                        mem_write_address_next = sel_write_addr;
                        mem_write_data_next    = sel_write_data;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_next = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (int'(grant) == i) begin
                            read_data_next[i*DATA_BITS +: DATA_BITS] = mem_read_data;
                            read_ready_next[i] = 1'b1;
                        end
                    end
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_next = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (int'(grant) == i) write_ready_next[i] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        busy_next = (state_next != IDLE);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one data-memory channel between `NUM_CONSUMERS` thread load-store units within a core. Collects the per-LSU read and write requests and grants them one at a time in round-robin order. Forwards each granted request to the memory interface and routes the response back as a single-cycle ready pulse. Sits between the LSU array and the memory controller port of the core.

## Interface
- `NUM_CONSUMERS`, 4, number of LSUs sharing the channel (≥2)
- `ADDR_BITS`, 8, memory address width
- `DATA_BITS`, 32, memory data width

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `consumer_read_valid`  in  NUM_CONSUMERS  per-LSU read request, held until its ready pulse
- `consumer_read_address`  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i at [i*ADDR_BITS +: ADDR_BITS]
- `consumer_read_ready`  out  NUM_CONSUMERS  one-cycle read completion pulse
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_BITS  packed read data; valid while matching ready is high
- `consumer_write_valid`  in  NUM_CONSUMERS  per-LSU write request
- `consumer_write_address`  in  NUM_CONSUMERS*ADDR_BITS  packed write address
- `consumer_write_data`  in  NUM_CONSUMERS*DATA_BITS  packed write data
- `consumer_write_ready`  out  NUM_CONSUMERS  one-cycle write completion pulse
- `mem_read_valid`  out  1  read request to memory, held until `mem_read_ready`
- `mem_read_address`  out  ADDR_BITS  read address
- `mem_read_ready`  in  1  memory read response strobe
- `mem_read_data`  in  DATA_BITS  read data, sampled with `mem_read_ready`
- `mem_write_valid`  out  1  write request to memory
- `mem_write_address`  out  ADDR_BITS  write address
- `mem_write_data`  out  DATA_BITS  write data
- `mem_write_ready`  in  1  memory write acknowledge
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELEASE. All outputs are registered.
- **IDLE:**
  - Search consumers starting at `rr_ptr`, wrapping modulo NUM_CONSUMERS. Select the first with read or write valid.
  - If the selected consumer has both valid, service the read. Its write remains pending and the consumer stays eligible.
  - On a read grant: latch grant index, set `mem_read_valid`=1, drive `mem_read_address` from that consumer, go to READ_WAIT.
  - On a write grant: set `mem_write_valid`=1, drive address and data, go to WRITE_WAIT.
  - On either grant: `rr_ptr` ← (grant+1) mod NUM_CONSUMERS.
- **READ_WAIT:** on `mem_read_ready`=1:
  - `mem_read_valid`←0.
  - Capture `mem_read_data` into the granted consumer's data slice.
  - `consumer_read_ready[grant]`←1.
  - Go to RELEASE.
- **WRITE_WAIT:** on `mem_write_ready`=1:
  - `mem_write_valid`←0.
  - `consumer_write_ready[grant]`←1.
  - Go to RELEASE.
- **RELEASE:** clear all ready bits and return to IDLE. This cycle keeps a consumer whose valid is still visible during its ready cycle from being granted twice.
- Per-consumer data registers hold their last value until that consumer's next read completes.
- Consumer address and data may change only while that consumer's valid is low. The arbiter samples them only at grant.
- A memory ready strobe of the non-pending kind, or any strobe in IDLE or RELEASE, is ignored.
- Consumer valids dropping while a request is outstanding does not abort the memory transaction. The response is still pulsed to the latched index.

## Timing
- **Reset** (`reset`=0 at an edge), including mid-transaction:
  - Goes to IDLE with `rr_ptr`=0 and grant=0.
  - All valid and ready outputs are 0; all address and data outputs are 0; `busy`=0.
  - An outstanding memory request is abandoned; late memory strobes are ignored.
- **Cycle sequence:**
  - Edge E0: IDLE sees a valid request; mem valid is high after E0.
  - Edge E1 (earliest): mem ready is sampled; consumer ready and data are high after E1.
  - Edge E2: RELEASE, ready drops.
  - Edge E3: the next grant is possible.
- Minimum 3 cycles from grant to grant. Minimum latency from consumer valid sampled to ready pulse is 2 cycles plus memory wait cycles.
- Consumer ready is high for exactly one cycle per granted request.
- Fairness: with all consumers continuously requesting, each is granted once per NUM_CONSUMERS grants.
- Reads and writes share a single outstanding slot; mem read and write valid are never high together.

## Test plan
- **Single read, zero-wait memory:**
  - Stimulus: consumer 2 read at address 0x40; memory returns 0xDEADBEEF at the first opportunity.
  - Response: `mem_read_valid` high for exactly 1 cycle with address 0x40. `consumer_read_ready`=4'b0100 for one cycle, 2 cycles after grant. Data slice 2 = 0xDEADBEEF.
- **Round robin:**
  - Stimulus: all 4 consumers request reads at once, each re-requesting 1 cycle after its ready pulse.
  - Response: grant order 0,1,2,3,0,1. No consumer is granted twice within 4 grants.
- **Mixed read and write:**
  - Stimulus: consumer 0 writes 0x12345678 to 0x10 while consumer 1 reads 0x10; memory write ready is delayed 3 cycles.
  - Response: write issued first with `mem_write_valid` held 4 cycles. Read issued 3 cycles after the write ack. Mem read and write valid never high together.
- **No double grant:**
  - Stimulus: consumer 3 holds valid through its ready cycle and drops it after.
  - Response: exactly one memory transaction and one ready pulse.
- **Reset mid-transaction:**
  - Stimulus: assert `reset`=0 during READ_WAIT, then release it and pulse `mem_read_ready`.
  - Response: all outputs 0 and `busy`=0 after the reset edge. The stale strobe produces no consumer ready. The next request is granted from consumer 0 first.
- **Stray strobe:**
  - Stimulus: pulse `mem_write_ready` while in READ_WAIT.
  - Response: ignored; still waiting, `mem_read_valid` remains 1.
